// File: rtl/axis_packet_tx.sv
// AXI-Stream packet transmitter: turns one command (length, id, dest, seed)
// into a registered packet of incrementing data with partial final tkeep.
module axis_packet_tx #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned TKEEPWIDTH = 4,
  parameter int unsigned TSTRBWIDTH = 4,
  parameter int unsigned TIDWIDTH   = 8,
  parameter int unsigned TDESTWIDTH = 8,
  parameter int unsigned LENWIDTH   = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LENWIDTH-1:0]   cmd_len,
  input  logic [TIDWIDTH-1:0]   cmd_tid,
  input  logic [TDESTWIDTH-1:0] cmd_tdest,
  input  logic [DWIDTH-1:0]     cmd_seed,
  output logic [DWIDTH-1:0]     tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast,
  output logic [TKEEPWIDTH-1:0] tkeep,
  output logic [TSTRBWIDTH-1:0] tstrb,
  output logic                  tuser,
  output logic [TIDWIDTH-1:0]   tid,
  output logic [TDESTWIDTH-1:0] tdest,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [15:0]           pkt_count
);

  localparam int unsigned BYTES = DWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t                state;
  logic [LENWIDTH-1:0]   beat;
  logic [LENWIDTH-1:0]   beat_next;
  logic [LENWIDTH-1:0]   last_beat;
  logic [TKEEPWIDTH-1:0] last_keep;

  logic [LENWIDTH-1:0]   cmd_last_beat;
  logic [LENWIDTH-1:0]   cmd_rem;
  logic [TKEEPWIDTH-1:0] cmd_keep;

  // Final beat index is (len-1)/BYTES, which never overflows LENWIDTH even
  // for the maximum length; it is only used when len is non-zero.
  assign cmd_last_beat = (cmd_len - LENWIDTH'(1)) / LENWIDTH'(BYTES);
  assign cmd_rem       = cmd_len % LENWIDTH'(BYTES);
  assign beat_next     = beat + LENWIDTH'(1);

  always_comb begin
    cmd_keep = '0;
    for (int unsigned i = 0; i < TKEEPWIDTH; i++) begin
      cmd_keep[i] = (cmd_rem == '0) || (LENWIDTH'(i) < cmd_rem);
    end
  end

  assign cmd_ready = (state == IDLE) && !areset;
  assign busy      = (state != IDLE);
  assign tstrb     = tkeep;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      beat      <= '0;
      last_beat <= '0;
      last_keep <= '0;
      tdata     <= '0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      tkeep     <= '0;
      tuser     <= 1'b0;
      tid       <= '0;
      tdest     <= '0;
      pkt_done  <= 1'b0;
      pkt_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            tid       <= cmd_tid;
            tdest     <= cmd_tdest;
            beat      <= '0;
            last_beat <= cmd_last_beat;
            last_keep <= cmd_keep;
            // Zero-length completes at acceptance; ZERO only holds off the next command.
            if (cmd_len == '0) begin
              state     <= ZERO;
              pkt_done  <= 1'b1;
              pkt_count <= pkt_count + 16'd1;
            end else begin
              state  <= SEND;
              tvalid <= 1'b1;
              tuser  <= 1'b1;
              tdata  <= cmd_seed;
              tlast  <= (cmd_last_beat == '0);
              tkeep  <= (cmd_last_beat == '0) ? cmd_keep : '1;
            end
          end
        end
        SEND: begin
          if (tready) begin
            if (tlast) begin
              state     <= IDLE;
              tvalid    <= 1'b0;
              tlast     <= 1'b0;
              tuser     <= 1'b0;
              pkt_done  <= 1'b1;
              pkt_count <= pkt_count + 16'd1;
            end else begin
              beat  <= beat_next;
              tdata <= tdata + DWIDTH'(1);
              tuser <= 1'b0;
              if (beat_next == last_beat) begin
                tlast <= 1'b1;
                tkeep <= last_keep;
              end
            end
          end
        end
        ZERO: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_tx.sv
// Directed bench for axis_packet_tx: fixed packets, backpressure, zero-length,
// maximum length and mid-packet reset, with hand-computed expectations.
module tb_axis_packet_tx;

  logic        aclk;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_tid;
  logic [7:0]  cmd_tdest;
  logic [31:0] cmd_seed;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [3:0]  tkeep;
  logic [3:0]  tstrb;
  logic        tuser;
  logic [7:0]  tid;
  logic [7:0]  tdest;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_count;

  int checks   = 0;
  int failures = 0;

  axis_packet_tx #(
    .DWIDTH(32), .TKEEPWIDTH(4), .TSTRBWIDTH(4),
    .TIDWIDTH(8), .TDESTWIDTH(8), .LENWIDTH(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_tid(cmd_tid), .cmd_tdest(cmd_tdest), .cmd_seed(cmd_seed),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .tkeep(tkeep), .tstrb(tstrb), .tuser(tuser), .tid(tid), .tdest(tdest),
    .busy(busy), .pkt_done(pkt_done), .pkt_count(pkt_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s: observed=timeout expected=pkt_done", tag);
  endtask

  // Presents a command for one cycle; returns at the negedge of cycle E+1.
  task automatic issue(input logic [15:0] len, input logic [31:0] seed,
                       input logic [7:0] id, input logic [7:0] dst);
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_seed  = seed;
    cmd_tid   = id;
    cmd_tdest = dst;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rseed;
    logic [3:0]  exp_keep;
    logic [31:0] last_data;
    logic [3:0]  last_keep;
    int len, bytes, lasts, k, cyc;
    bit done;

    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_tid   = '0;
    cmd_tdest = '0;
    cmd_seed  = '0;
    tready    = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tkeep", 64'(tkeep), 64'd0);
    check("rst_tuser_tlast", 64'({tuser, tlast}), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // 8 bytes: two full beats
    issue(16'd8, 32'h10, 8'd3, 8'd5);
    check("p1_b0_tvalid", 64'(tvalid), 64'd1);
    check("p1_b0_tdata", 64'(tdata), 64'h10);
    check("p1_b0_tkeep", 64'(tkeep), 64'hF);
    check("p1_b0_tuser_tlast", 64'({tuser, tlast}), 64'b10);
    check("p1_b0_tid_tdest", 64'({tid, tdest}), 64'h0305);
    check("p1_b0_busy_ready", 64'({busy, cmd_ready}), 64'b10);
    @(negedge aclk);
    check("p1_b1_tdata", 64'(tdata), 64'h11);
    check("p1_b1_tkeep", 64'(tkeep), 64'hF);
    check("p1_b1_tuser_tlast", 64'({tuser, tlast}), 64'b01);
    check("p1_b1_tid_tdest", 64'({tid, tdest}), 64'h0305);
    @(negedge aclk);
    check("p1_end", 64'({tvalid, pkt_done, cmd_ready}), 64'b011);
    check("p1_count", 64'(pkt_count), 64'd1);
    @(negedge aclk);
    check("p1_done_pulse", 64'(pkt_done), 64'd0);

    // 6 bytes with wrapping data
    issue(16'd6, 32'hFFFF_FFFF, 8'd1, 8'd2);
    check("p2_b0_tdata", 64'(tdata), 64'hFFFF_FFFF);
    check("p2_b0_tkeep", 64'(tkeep), 64'hF);
    check("p2_b0_tlast", 64'(tlast), 64'd0);
    @(negedge aclk);
    check("p2_b1_tdata", 64'(tdata), 64'h0);
    check("p2_b1_tkeep", 64'(tkeep), 64'h3);
    check("p2_b1_tstrb", 64'(tstrb), 64'h3);
    check("p2_b1_tlast", 64'(tlast), 64'd1);
    @(negedge aclk);
    check("p2_end", 64'({tvalid, pkt_done}), 64'b01);
    check("p2_count", 64'(pkt_count), 64'd2);

    // 3 bytes, tready 0,0,1
    tready = 1'b0;
    issue(16'd3, 32'h55, 8'hA1, 8'hB2);
    check("p3_c0", 64'({tvalid, tuser, tlast, tkeep, tstrb}), 64'b111_0111_0111);
    check("p3_c0_tdata", 64'(tdata), 64'h55);
    @(negedge aclk);
    check("p3_c1", 64'({tvalid, tuser, tlast, tkeep, tstrb}), 64'b111_0111_0111);
    check("p3_c1_payload", 64'({tdata, tid, tdest}), 64'h0000_0055_A1B2);
    @(negedge aclk);
    check("p3_c2", 64'({tvalid, tuser, tlast, tkeep, tstrb}), 64'b111_0111_0111);
    check("p3_c2_payload", 64'({tdata, tid, tdest}), 64'h0000_0055_A1B2);
    tready = 1'b1;
    @(negedge aclk);
    check("p3_end", 64'({tvalid, pkt_done}), 64'b01);
    check("p3_count", 64'(pkt_count), 64'd3);

    // Zero length, cmd_valid held while busy
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_len   = 16'd0;
    @(negedge aclk);
    check("z_e1", 64'({tvalid, pkt_done, busy, cmd_ready}), 64'b0110);
    check("z_e1_count", 64'(pkt_count), 64'd4);
    @(negedge aclk);
    check("z_e2", 64'({tvalid, pkt_done, busy, cmd_ready}), 64'b0001);
    check("z_e2_count", 64'(pkt_count), 64'd4);
    cmd_valid = 1'b0;
    @(negedge aclk);
    check("z_e3", 64'({tvalid, pkt_done, busy}), 64'b000);
    check("z_e3_count", 64'(pkt_count), 64'd4);

    // 100 random packets under random backpressure
    for (int p = 0; p < 100; p++) begin
      len   = $urandom_range(1, 64);
      rseed = $urandom;
      issue(16'(len), rseed, 8'(p), 8'(p + 1));
      bytes = 0; lasts = 0; k = 0; cyc = 0; done = 1'b0;
      while (!done) begin
        if (pkt_done) begin
          done = 1'b1;
        end else if (cyc > 1000) begin
          timeout_fail("rand_timeout");
          done = 1'b1;
        end else begin
          tready = 1'($urandom_range(0, 1));
          if (tvalid && tready) begin
            check("rand_tdata", 64'(tdata), 64'(rseed + 32'(k)));
            check("rand_tuser", 64'(tuser), 64'(k == 0));
            if (tlast) begin
              lasts++;
              exp_keep = (len % 4 == 0) ? 4'hF : 4'((1 << (len % 4)) - 1);
            end else begin
              exp_keep = 4'hF;
            end
            check("rand_tkeep", 64'(tkeep), 64'(exp_keep));
            bytes += $countones(tkeep);
            k++;
          end
          @(negedge aclk);
          cyc++;
        end
      end
      check("rand_bytes", 64'(bytes), 64'(len));
      check("rand_tlast_count", 64'(lasts), 64'd1);
    end
    check("rand_pkt_count", 64'(pkt_count), 64'd104);

    // Maximum length: 65535 bytes -> 16384 beats, final keep 0x7
    tready = 1'b1;
    issue(16'hFFFF, 32'h0, 8'h0, 8'h0);
    bytes = 0; lasts = 0; cyc = 0; done = 1'b0;
    last_data = '0; last_keep = '0;
    while (!done) begin
      if (pkt_done) begin
        done = 1'b1;
      end else if (cyc > 20000) begin
        timeout_fail("max_timeout");
        done = 1'b1;
      end else begin
        if (tvalid) begin
          bytes++;
          if (tlast) begin
            lasts++;
            last_data = tdata;
            last_keep = tkeep;
          end
        end
        @(negedge aclk);
        cyc++;
      end
    end
    check("max_beats", 64'(bytes), 64'd16384);
    check("max_tlast_count", 64'(lasts), 64'd1);
    check("max_last_tdata", 64'(last_data), 64'h3FFF);
    check("max_last_tkeep", 64'(last_keep), 64'h7);
    check("max_pkt_count", 64'(pkt_count), 64'd105);

    // Reset at beat 2 of a 10-beat packet
    issue(16'd40, 32'h100, 8'h7, 8'h9);
    check("rp_b0_tdata", 64'(tdata), 64'h100);
    @(negedge aclk);
    @(negedge aclk);
    check("rp_b2_tdata", 64'(tdata), 64'h102);
    areset = 1'b1;
    @(negedge aclk);
    check("rp_rst", 64'({tvalid, tlast, pkt_done, cmd_ready}), 64'b0000);
    check("rp_rst_count", 64'(pkt_count), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("rp_after", 64'({tvalid, busy, cmd_ready, pkt_done}), 64'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
